opb_register_simulink2ppc_latched: RTL
======================================

// Module: opb_register_simulink2ppc_latched
// PURPOSE
//  OPB slave that carries user-fabric data to the PowerPC, the opposite direction to the ppc2simulink registers.
//  Fabric logic presents a 32-bit word with a valid strobe. The block latches the word, flags it as new and
//  counts overruns, and the PPC polls it over OPB. Both sides share OPB_Clk, so no clock-domain crossing is needed.
// PARAMETERS
//  C_BASEADDR    32'h01001200  first byte address of the 3-word register window
//  C_HIGHADDR    32'h010012FF  last decoded byte address; hits above offset 0x8 read 0
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex5"     target family string; not used by the logic
// PORTS
//  OPB_Clk          in   1   sole clock; OPB and user logic both use it
//  OPB_Rst_n        in   1   asynchronous reset, active low
//  OPB_ABus         in   32  [0:31] address
//  OPB_BE           in   4   [0:3] byte enables; ignored because all accesses are full-word
//  OPB_DBus         in   32  [0:31] write data
//  OPB_RNW          in   1   1 = read, 0 = write
//  OPB_select       in   1   bus cycle active
//  OPB_seqAddr      in   1   ignored; no burst support
//  Sl_DBus          out  32  [0:31] read data; 0 whenever Sl_xferAck is 0
//  Sl_xferAck       out  1   one-cycle transfer acknowledge
//  Sl_errAck        out  1   constant 0
//  Sl_retry         out  1   constant 0
//  Sl_toutSup       out  1   constant 0
//  user_data_in     in   32  [31:0] word from fabric
//  user_data_valid  in   1   capture strobe, one cycle per word
//  user_data_taken  out  1   one-cycle pulse when the PPC reads DATA
// BEHAVIOUR
//  Reset (OPB_Rst_n = 0, async): data_reg = 0, new_flag = 0, ovr_cnt = 0, freeze = 0, FSM = IDLE,
//   Sl_DBus = 0, Sl_xferAck = 0, user_data_taken = 0. A reset mid-transfer aborts the transfer with no ack.
//  Register map (word offsets from C_BASEADDR):
//   0x0 DATA (RO)    read returns data_reg; a read clears new_flag and pulses user_data_taken.
//   0x4 STATUS (RO)  bit31 (OPB bit 0) = new_flag; bits[15:0] = ovr_cnt; other bits read 0.
//   0x8 CTRL (RW)    bit0 = freeze (data_reg ignores valid while 1); bit1 write-1 clears ovr_cnt
//                    (self-clearing, reads 0). Other bits are ignored on write and read 0.
//   Writes to DATA or STATUS are acked and discarded.
//  Hit = OPB_select & (OPB_ABus >= C_BASEADDR) & (OPB_ABus <= C_HIGHADDR).
//  FSM (registered):
//   IDLE -> ACK when hit.
//   ACK  -> WAIT unconditionally.
//   WAIT -> IDLE when OPB_select = 0.
//  Timing: Sl_xferAck = 1 only in the ACK cycle, one cycle after the hit is sampled (2-cycle access).
//   Sl_DBus is driven in that same cycle. Exactly one ack is given per select assertion.
//  Read data and side effects are sampled and applied on the IDLE->ACK edge.
//  Capture: on user_data_valid with freeze = 0, data_reg <= user_data_in and new_flag <= 1.
//   If new_flag is already 1 and no DATA read occurs in the same cycle, ovr_cnt increments.
//   ovr_cnt saturates at 16'hFFFF.
//  Collisions:
//   - valid in the same cycle as a DATA read: the read returns the old word, new_flag stays 1,
//     and ovr_cnt does not increment.
//   - valid with freeze = 1: the word is dropped, flags are unchanged, and ovr_cnt increments
//     (saturating).
//   - CTRL clear and an overrun in the same cycle: the clear wins and ovr_cnt = 0.
//  Bit order: OPB bit i corresponds to internal bit (31 - i) on both buses.
// TESTING
//  1. Reset, then read DATA/STATUS/CTRL -> all 0; Sl_xferAck pulses once per read, 1 cycle after select.
//  2. valid with 0xDEADBEEF, then read STATUS -> 0x80000000; read DATA -> 0xDEADBEEF,
//     user_data_taken pulses; read STATUS -> 0.
//  3. Three valids with no read -> STATUS = 0x80000002; write CTRL = 0x2 -> STATUS = 0x80000000.
//  4. valid with 0x11 in the same cycle as a DATA read of old word 0x5 -> read returns 0x5;
//     next DATA read returns 0x11.
//  5. Write CTRL = 0x1, then valid with 0x77 -> DATA unchanged, ovr_cnt = 1; CTRL reads 0x1.
//  6. Hold select for 5 cycles -> exactly one ack. Out-of-range address -> no ack.
//     Assert reset during WAIT -> outputs 0 immediately.

Source files
------------

// File: rtl/opb_register_simulink2ppc_latched.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_latched: fabric-to-PPC latched word over OPB, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module opb_register_simulink2ppc_latched #(
  parameter logic [31:0] C_BASEADDR   = 32'h01001200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010012FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid,
  output logic        user_data_taken
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic [31:0] dbus_q;
  logic        taken_q;

  logic [31:0] data_q, data_d;
  logic        new_flag_q, new_flag_d;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;
  logic        freeze_q, freeze_d;

  // [0:31] buses map MSB-first onto these [31:0] vectors, giving OPB bit i = bit (31-i).
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_offset;
  logic        w_hit;
  logic        w_start;
  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_sel_ctrl;
  logic        w_data_rd;
  logic        w_ctrl_wr;
  logic        w_ovr_inc;
  logic [31:0] w_rdata;

  assign w_addr   = OPB_ABus;
  assign w_wdata  = OPB_DBus;
  assign w_offset = w_addr - C_BASEADDR;
  assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_start  = (state_q == ST_IDLE) && w_hit;

  assign w_sel_data   = (w_offset[31:2] == 30'd0);
  assign w_sel_status = (w_offset[31:2] == 30'd1);
  assign w_sel_ctrl   = (w_offset[31:2] == 30'd2);

  assign w_data_rd = w_start && OPB_RNW && w_sel_data;
  assign w_ctrl_wr = w_start && !OPB_RNW && w_sel_ctrl;

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel_data)        w_rdata = data_q;
    else if (w_sel_status) w_rdata = {new_flag_q, 15'd0, ovr_cnt_q};
    else if (w_sel_ctrl)   w_rdata = {31'd0, freeze_q};
  end

  // A frozen capture always counts as an overrun; a same-cycle DATA read consumes the old word.
  assign w_ovr_inc = user_data_valid && (freeze_q || (new_flag_q && !w_data_rd));

  always_comb begin
    data_d     = data_q;
    new_flag_d = new_flag_q;
    ovr_cnt_d  = ovr_cnt_q;
    freeze_d   = freeze_q;
    if (user_data_valid && !freeze_q) begin
      data_d     = user_data_in;
      new_flag_d = 1'b1;
    end else if (w_data_rd) begin
      new_flag_d = 1'b0;
    end
    if (w_ovr_inc && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_d = ovr_cnt_q + 16'd1;
    if (w_ctrl_wr) begin
      freeze_d = w_wdata[0];
      if (w_wdata[1]) ovr_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q     <= 32'd0;
      new_flag_q <= 1'b0;
      ovr_cnt_q  <= 16'd0;
      freeze_q   <= 1'b0;
    end else begin
      data_q     <= data_d;
      new_flag_q <= new_flag_d;
      ovr_cnt_q  <= ovr_cnt_d;
      freeze_q   <= freeze_d;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= 32'd0;
      taken_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      dbus_q  <= 32'd0;
      taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_hit) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dbus_q  <= OPB_RNW ? w_rdata : 32'd0;
            taken_q <= w_data_rd;
          end
        end
        ST_ACK:  state_q <= ST_WAIT;
        ST_WAIT: if (!OPB_select) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Sl_DBus         = dbus_q;
  assign Sl_xferAck      = ack_q;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_taken = taken_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPB_BE, OPB_seqAddr, w_wdata[31:2], w_offset[1:0]};

endmodule

`default_nettype wire
